// File: rtl/dma_multichannel_reader.sv
// Multi-channel AXI4 read DMA: per-channel command FIFOs, round-robin engine, 4 KB-safe bursts, beat packing.
// Optional irq status registers are enabled with `define GARUDA_DMA_IRQ_EN.
module dma_multichannel_reader #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CMD_DEPTH     = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned OUT_WIDTH     = 512,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [$clog2(NUM_CH)-1:0] cmd_ch_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_src_addr_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_size_i,
  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  output logic [ADDR_WIDTH-1:0]     axi_araddr_o,
  output logic [7:0]                axi_arlen_o,
  output logic [2:0]                axi_arsize_o,
  output logic [1:0]                axi_arburst_o,
  output logic [$clog2(NUM_CH)-1:0] axi_arid_o,
  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o,
  input  logic [DATA_WIDTH-1:0]     axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rlast_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [OUT_WIDTH-1:0]      out_data_o,
  output logic [$clog2(NUM_CH)-1:0] out_ch_o,
  output logic                      out_last_o,
  output logic [NUM_CH-1:0]         ch_busy_o,
  input  logic                      irq_enable_i,
  input  logic [NUM_CH-1:0]         irq_clear_i,
  output logic [NUM_CH-1:0]         irq_done_o,
  output logic [NUM_CH-1:0]         irq_err_o,
  output logic                      irq_o
);

  localparam int unsigned CH_W       = $clog2(NUM_CH);
  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned PACK       = OUT_WIDTH / DATA_WIDTH;
  localparam int unsigned IDX_W      = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned PTR_W      = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(CMD_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FIN} state_t;

  state_t                 state_q;
  logic [CH_W-1:0]        cur_ch_q, last_ch_q;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, rem_q;
  logic                   err_q;
  logic [IDX_W-1:0]       idx_q;
  logic [OUT_WIDTH-1:0]   pack_q, pack_nxt;

  logic [ADDR_WIDTH-1:0]  fifo_addr  [NUM_CH][CMD_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_beats [NUM_CH][CMD_DEPTH];
  logic [PTR_W-1:0]       wr_ptr [NUM_CH];
  logic [PTR_W-1:0]       rd_ptr [NUM_CH];
  logic [CNT_W-1:0]       fifo_cnt [NUM_CH];

  logic                   push, pop, grant_vld, beat_hs, beat_err, cmd_end, fin_exit;
  logic [CH_W-1:0]        grant_ch;
  logic [NUM_CH-1:0]      push_vec, pop_vec;
  logic [ADDR_WIDTH-1:0]  head_addr, head_beats, nb_addr, nb_rem, next_addr;
  logic [8:0]             nb;

  // Beats in the next burst: limited by max length, remaining beats and the next 4 KB boundary.
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [ADDR_WIDTH-1:0] rem);
    logic [11:0]           aligned;
    logic [12:0]           to_4k;
    logic [ADDR_WIDTH-1:0] lim;
    aligned = addr[11:0] & ~12'(BEAT_BYTES - 1);
    to_4k   = (13'h1000 - {1'b0, aligned}) >> SIZE_SHIFT;
    lim     = ADDR_WIDTH'(MAX_BURST_LEN);
    if (rem < lim) lim = rem;
    if (ADDR_WIDTH'(to_4k) < lim) lim = ADDR_WIDTH'(to_4k);
    return 9'(lim);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == CMD_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready_o   = (fifo_cnt[cmd_ch_i] != CNT_W'(CMD_DEPTH));
  assign push          = cmd_valid_i && cmd_ready_o;
  assign pop           = (state_q == S_IDLE) && grant_vld;
  assign head_addr     = fifo_addr[grant_ch][rd_ptr[grant_ch]];
  assign head_beats    = fifo_beats[grant_ch][rd_ptr[grant_ch]];
  assign axi_arsize_o  = 3'(SIZE_SHIFT);
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = (state_q == S_DATA) && !out_valid_o;
  assign beat_hs       = axi_rvalid_i && axi_rready_o;
  assign fin_exit      = (state_q == S_FIN) && !out_valid_o;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      if (!grant_vld && fifo_cnt[CH_W'(32'(last_ch_q) + i)] != '0) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(32'(last_ch_q) + i);
      end
    end
  end

  always_comb begin
    push_vec  = '0;
    pop_vec   = '0;
    ch_busy_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      push_vec[c]  = push && (cmd_ch_i == CH_W'(c));
      pop_vec[c]   = pop && (grant_ch == CH_W'(c));
      ch_busy_o[c] = (fifo_cnt[c] != '0) || ((state_q != S_IDLE) && (cur_ch_q == CH_W'(c)));
    end
  end

  always_comb begin
    beat_err = err_q || (axi_rresp_i != 2'b00);
    cmd_end  = axi_rlast_i && ((rem_q == '0) || beat_err);
    pack_nxt = pack_q;
    pack_nxt[idx_q*DATA_WIDTH +: DATA_WIDTH] = axi_rdata_i;
    nb_addr   = (state_q == S_IDLE) ? head_addr : cur_addr_q;
    nb_rem    = (state_q == S_IDLE) ? head_beats : rem_q;
    nb        = burst_beats(nb_addr, nb_rem);
    next_addr = nb_addr + (ADDR_WIDTH'(nb) << SIZE_SHIFT);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[cmd_ch_i][wr_ptr[cmd_ch_i]]  <= cmd_src_addr_i;
      fifo_beats[cmd_ch_i][wr_ptr[cmd_ch_i]] <= ADDR_WIDTH'(cmd_size_i >> SIZE_SHIFT);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rst_i) begin
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        fifo_cnt[c] <= '0;
      end else begin
        if (push_vec[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
        if (pop_vec[c])  rd_ptr[c] <= ptr_inc(rd_ptr[c]);
        if (push_vec[c] && !pop_vec[c])      fifo_cnt[c] <= fifo_cnt[c] + 1'b1;
        else if (!push_vec[c] && pop_vec[c]) fifo_cnt[c] <= fifo_cnt[c] - 1'b1;
      end
    end
  end

  // Engine FSM; a granted channel keeps the engine until its command finishes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      last_ch_q     <= CH_W'(NUM_CH - 1);
      cur_ch_q      <= '0;
      cur_addr_q    <= '0;
      rem_q         <= '0;
      err_q         <= 1'b0;
      idx_q         <= '0;
      pack_q        <= '0;
      axi_arvalid_o <= 1'b0;
      axi_araddr_o  <= '0;
      axi_arlen_o   <= '0;
      axi_arid_o    <= '0;
      out_valid_o   <= 1'b0;
      out_data_o    <= '0;
      out_ch_o      <= '0;
      out_last_o    <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            cur_ch_q  <= grant_ch;
            last_ch_q <= grant_ch;
            err_q     <= 1'b0;
            idx_q     <= '0;
            pack_q    <= '0;
            if (head_beats == '0) begin
              state_q <= S_FIN;
            end else begin
              state_q       <= S_ADDR;
              axi_arvalid_o <= 1'b1;
              axi_araddr_o  <= head_addr;
              axi_arlen_o   <= 8'(nb - 9'd1);
              axi_arid_o    <= grant_ch;
              cur_addr_q    <= next_addr;
              rem_q         <= head_beats - ADDR_WIDTH'(nb);
            end
          end
        end
        S_ADDR: begin
          if (axi_arready_i) begin
            axi_arvalid_o <= 1'b0;
            state_q       <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_hs) begin
            err_q <= beat_err;
            if ((32'(idx_q) == PACK - 1) || cmd_end) begin
              out_valid_o <= 1'b1;
              out_data_o  <= pack_nxt;
              out_ch_o    <= cur_ch_q;
              out_last_o  <= cmd_end;
              pack_q      <= '0;
              idx_q       <= '0;
            end else begin
              pack_q <= pack_nxt;
              idx_q  <= idx_q + 1'b1;
            end
            if (axi_rlast_i) begin
              if (cmd_end) begin
                state_q <= S_FIN;
              end else begin
                state_q       <= S_ADDR;
                axi_arvalid_o <= 1'b1;
                axi_araddr_o  <= cur_addr_q;
                axi_arlen_o   <= 8'(nb - 9'd1);
                axi_arid_o    <= cur_ch_q;
                cur_addr_q    <= next_addr;
                rem_q         <= rem_q - ADDR_WIDTH'(nb);
              end
            end
          end
        end
        S_FIN: begin
          if (fin_exit) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef GARUDA_DMA_IRQ_EN
  logic [NUM_CH-1:0] done_q, errst_q, done_set, err_set;

  assign done_set = fin_exit ? (NUM_CH'(1) << cur_ch_q) : '0;
  assign err_set  = (fin_exit && err_q) ? (NUM_CH'(1) << cur_ch_q) : '0;

  // W1C status; a set in the same cycle as its clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q  <= '0;
      errst_q <= '0;
    end else begin
      done_q  <= (done_q & ~irq_clear_i) | done_set;
      errst_q <= (errst_q & ~irq_clear_i) | err_set;
    end
  end

  assign irq_done_o = done_q & {NUM_CH{irq_enable_i}};
  assign irq_err_o  = errst_q & {NUM_CH{irq_enable_i}};
  assign irq_o      = |(irq_done_o | irq_err_o);
`else
  logic unused_irq;
  assign unused_irq = ^{irq_enable_i, irq_clear_i};
  assign irq_done_o = '0;
  assign irq_err_o  = '0;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dma_multichannel_reader.sv
// Directed bench for dma_multichannel_reader with a command-level model, AXI slave and output scoreboard.
module tb_dma_multichannel_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_ch;
  logic [31:0]  cmd_addr, cmd_size;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst, arid;
  logic         rvalid, rready, rlast;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         out_valid, out_ready, out_last;
  logic [511:0] out_data;
  logic [1:0]   out_ch;
  logic [3:0]   ch_busy, irq_clear, irq_done, irq_err;
  logic         irq_enable, irq;

  always #5 clk = ~clk;

  dma_multichannel_reader dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_ch_i(cmd_ch),
    .cmd_src_addr_i(cmd_addr), .cmd_size_i(cmd_size),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr),
    .axi_arlen_o(arlen), .axi_arsize_o(arsize), .axi_arburst_o(arburst), .axi_arid_o(arid),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata),
    .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_last_o(out_last), .ch_busy_o(ch_busy),
    .irq_enable_i(irq_enable), .irq_clear_i(irq_clear), .irq_done_o(irq_done),
    .irq_err_o(irq_err), .irq_o(irq)
  );

  typedef struct packed { logic [1:0] ch; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [1:0] ch; logic [511:0] data; logic last; } ow_t;

  ar_t          exp_ar[$];
  ow_t          exp_out[$];
  logic [1:0]   ar_log[$];
  logic [31:0]  ar_addr_log[$];
  logic [7:0]   ar_len_log[$];
  logic [3:0]   m_done = 4'b0, m_err = 4'b0;
  logic [31:0]  err_addr = 32'hFFFF_FFFF;
  int           n_chk = 0, n_fail = 0;
  logic [511:0] lo_data;
  logic [1:0]   lo_ch;
  logic         lo_last;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [3:0] irq_exp(input logic [3:0] m);
`ifdef GARUDA_DMA_IRQ_EN
    return m & {4{irq_enable}};
`else
    return 4'b0 & m;
`endif
  endfunction

  // Expected bursts and output words of one command, derived from the byte range.
  task automatic model_cmd(input logic [1:0] ch, input logic [31:0] addr, input logic [31:0] size);
    int unsigned beats, j, b, to4k, idx;
    logic [31:0] a, base, ba;
    logic [511:0] w;
    bit errd, fin;
    beats = size >> 2; j = 0; idx = 0; a = addr; base = addr & ~32'h3; w = '0; errd = 0;
    m_done[ch] = 1'b1;
    while (j < beats && !errd) begin
      to4k = (4096 - int'(a[11:0] & 12'hFFC)) / 4;
      b = 16;
      if (beats - j < b) b = beats - j;
      if (to4k < b) b = to4k;
      exp_ar.push_back('{ch, a, 8'(b - 1)});
      for (int unsigned k = 0; k < b; k++) begin
        ba = base + 32'(4 * (j + k));
        w[idx*32 +: 32] = beat_data(ba);
        if (ba == err_addr) errd = 1;
        fin = (k == b - 1) && ((j + b == beats) || errd);
        if (idx == 15 || fin) begin
          exp_out.push_back('{ch, w, fin});
          w = '0; idx = 0;
        end else idx++;
      end
      j += b;
      a = a + 32'(4 * b);
    end
    if (errd) m_err[ch] = 1'b1;
  endtask

  // AXI read slave: answers each AR in order with address-derived data.
  ar_t sq[$];
  int  beat_k = 0;
  logic s_ar_hs, s_r_hs;
  ar_t s_cap;
  logic [31:0] s_ba;
  initial begin
    arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    forever begin
      @(negedge clk);
      s_ar_hs = arvalid && arready;
      s_cap   = '{arid, araddr, arlen};
      s_r_hs  = rvalid && rready;
      @(posedge clk); #1;
      if (rst) begin
        sq.delete(); beat_k = 0;
      end else begin
        if (s_r_hs) begin
          if (beat_k == int'(sq[0].len)) begin sq.pop_front(); beat_k = 0; end
          else beat_k++;
        end
        if (s_ar_hs) sq.push_back(s_cap);
      end
      if (sq.size() > 0) begin
        s_ba   = (sq[0].addr & ~32'h3) + 32'(4 * beat_k);
        rvalid = 1'b1;
        rdata  = beat_data(s_ba);
        rresp  = (s_ba == err_addr) ? 2'b10 : 2'b00;
        rlast  = (beat_k == int'(sq[0].len));
      end else begin
        rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
      end
    end
  end

  // Scoreboard: checks every AR and output handshake, plus output hold behaviour.
  int fi, pend;
  logic hold_prev = 1'b0;
  logic [511:0] prev_data;
  logic [2:0] prev_meta;
  always @(negedge clk) begin
    if (rst) hold_prev = 1'b0;
    else begin
      if (arvalid && arready) begin
        fi = -1;
        for (int i = 0; i < exp_ar.size(); i++) if (fi < 0 && exp_ar[i].ch == arid) fi = i;
        chk("ar_known", fi >= 0, 1);
        if (fi >= 0) begin
          chk("ar_addr", araddr, exp_ar[fi].addr);
          chk("ar_len", arlen, exp_ar[fi].len);
          exp_ar.delete(fi);
        end
        chk("ar_size", arsize, 3'd2);
        chk("ar_burst", arburst, 2'b01);
        if (ar_log.size() > 0 && ar_log[ar_log.size()-1] != arid) begin
          pend = 0;
          foreach (exp_ar[i]) if (exp_ar[i].ch == ar_log[ar_log.size()-1]) pend++;
          chk("ar_ch_hold", pend, 0);
        end
        ar_log.push_back(arid); ar_addr_log.push_back(araddr); ar_len_log.push_back(arlen);
      end
      if (out_valid) begin
        chk("rready_low", rready, 1'b0);
        if (hold_prev) begin
          chk("out_stable_data", out_data, prev_data);
          chk("out_stable_meta", {out_ch, out_last}, prev_meta);
        end
        if (out_ready) begin
          fi = -1;
          for (int i = 0; i < exp_out.size(); i++) if (fi < 0 && exp_out[i].ch == out_ch) fi = i;
          chk("out_known", fi >= 0, 1);
          if (fi >= 0) begin
            chk("out_data", out_data, exp_out[fi].data);
            chk("out_last", out_last, exp_out[fi].last);
            exp_out.delete(fi);
          end
          lo_data = out_data; lo_ch = out_ch; lo_last = out_last;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_meta = {out_ch, out_last};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] addr, input logic [31:0] size);
    int t;
    cmd_ch = ch; cmd_addr = addr; cmd_size = size; cmd_valid = 1'b1;
    #1;
    t = 0;
    while (!cmd_ready && t < 500) begin tick(1); t++; end
    chk("push_ready", cmd_ready, 1'b1);
    if (cmd_ready) model_cmd(ch, addr, size);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string nm);
    int t;
    t = 0;
    tick(2);
    while ((ch_busy != 0 || out_valid || exp_out.size() != 0) && t < 3000) begin tick(1); t++; end
    chk({nm, "_timeout"}, t < 3000, 1);
    chk({nm, "_ar_left"}, exp_ar.size(), 0);
    chk({nm, "_out_left"}, exp_out.size(), 0);
  endtask

  task automatic check_irq(input string nm);
    chk({nm, "_irq_done"}, irq_done, irq_exp(m_done));
    chk({nm, "_irq_err"}, irq_err, irq_exp(m_err));
    chk({nm, "_irq"}, irq, |(irq_exp(m_done) | irq_exp(m_err)));
  endtask

  task automatic clear_irq(input logic [3:0] mask);
    irq_clear = mask; tick(1); irq_clear = 4'b0;
    m_done &= ~mask; m_err &= ~mask;
  endtask

  task automatic clear_logs();
    ar_log.delete(); ar_addr_log.delete(); ar_len_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_addr = '0; cmd_size = '0;
    out_ready = 1'b1; irq_enable = 1'b1; irq_clear = '0;
    tick(3);
    rst = 1'b0; #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arsize", arsize, 3'd2);
    chk("rst_arburst", arburst, 2'b01);
    chk("rst_rready", rready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 512'h0);
    chk("rst_ch_busy", ch_busy, 4'h0);
    chk("rst_irq", {irq_done, irq_err, irq}, 9'h0);
    tick(1);

    // Single full-word command on ch0, with AR latency.
    clear_logs();
    push(2'd0, 32'h1000, 32'd64);
    chk("t1_model_ars", exp_ar.size(), 1);
    chk("t1_model_words", exp_out.size(), 1);
    chk("t1_arvalid_t1", arvalid, 1'b0);
    tick(1);
    chk("t1_arvalid_t2", arvalid, 1'b1);
    chk("t1_araddr", araddr, 32'h1000);
    chk("t1_arlen", arlen, 8'd15);
    chk("t1_arid", arid, 2'd0);
    wait_quiet("t1");
    chk("t1_ar_count", ar_log.size(), 1);
    chk("t1_lane0", lo_data[31:0], beat_data(32'h1000));
    chk("t1_lane15", lo_data[511:480], beat_data(32'h103C));
    chk("t1_out_last", lo_last, 1'b1);
    chk("t1_out_ch", lo_ch, 2'd0);
    check_irq("t1");
`ifdef GARUDA_DMA_IRQ_EN
    chk("t1_irq_done_lit", irq_done, 4'b0001);
`endif
    clear_irq(4'b0001);
    check_irq("t1c");

    // 4 KB split on ch1, with ch2 and ch0 queued behind it.
    clear_logs();
    push(2'd1, 32'h0FF8, 32'd32);
    push(2'd2, 32'h2000, 32'd128);
    push(2'd0, 32'h3004, 32'd20);
    wait_quiet("t2");
    chk("t2_ar_count", ar_log.size(), 5);
    if (ar_log.size() == 5) begin
      chk("t2_ar0_addr", ar_addr_log[0], 32'h0FF8);
      chk("t2_ar0_len", ar_len_log[0], 8'd1);
      chk("t2_ar1_addr", ar_addr_log[1], 32'h1000);
      chk("t2_ar1_len", ar_len_log[1], 8'd5);
      chk("t2_order", {ar_log[0], ar_log[1], ar_log[2], ar_log[3], ar_log[4]},
          {2'd1, 2'd1, 2'd2, 2'd2, 2'd0});
    end
    chk("t2_last_ch", lo_ch, 2'd0);
    chk("t2_lane4", lo_data[159:128], beat_data(32'h3014));
    chk("t2_tail_zero", lo_data[511:160], 352'h0);
    check_irq("t2");
    clear_irq(4'b1111);

    // Zero-beat commands and an address wrap.
    clear_logs();
    push(2'd3, 32'h4000, 32'd0);
    push(2'd3, 32'h4100, 32'd3);
    push(2'd1, 32'hFFFF_FFF0, 32'd32);
    wait_quiet("t3");
    chk("t3_ar_count", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
      chk("t3_wrap_ar0", {ar_addr_log[0], ar_len_log[0]}, {32'hFFFF_FFF0, 8'd3});
      chk("t3_wrap_ar1", {ar_addr_log[1], ar_len_log[1]}, {32'h0000_0000, 8'd3});
    end
    irq_enable = 1'b0; #1;
    check_irq("t3_dis");
    irq_enable = 1'b1; #1;
    check_irq("t3");
    clear_irq(4'b1111);

    // Error response on beat 3 of the first of two bursts.
    clear_logs();
    err_addr = 32'h500C;
    push(2'd2, 32'h5000, 32'd96);
    chk("t4_model_ars", exp_ar.size(), 1);
    wait_quiet("t4");
    chk("t4_ar_count", ar_log.size(), 1);
    chk("t4_out_last", lo_last, 1'b1);
    check_irq("t4");
`ifdef GARUDA_DMA_IRQ_EN
    chk("t4_irq_err_lit", irq_err, 4'b0100);
`endif
    err_addr = 32'hFFFF_FFFF;
    clear_irq(4'b1111);

    // Output stall: FIFO fills behind the held word and further pushes are refused.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(2'd0, 32'h7000 + 32'(64 * i), 32'd64);
    cmd_ch = 2'd0; cmd_addr = 32'h8000; cmd_size = 32'd64; cmd_valid = 1'b1; #1;
    chk("t5_full_ready", cmd_ready, 1'b0);
    cmd_ch = 2'd1; #1;
    chk("t5_other_ready", cmd_ready, 1'b1);
    cmd_ch = 2'd0; #1;
    tick(1);
    cmd_valid = 1'b0;
    tick(30);
    chk("t5_stall_valid", out_valid, 1'b1);
    chk("t5_stall_rready", rready, 1'b0);
    chk("t5_busy", ch_busy, 4'b0001);
    out_ready = 1'b1;
    wait_quiet("t5");
    chk("t5_ar_count", ar_log.size(), 5);
    check_irq("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
